// File: rtl/soc_pkg.sv
// Shared constants and state encodings for the UART program loader.
package soc_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [1:0] {IDLE, LEN, DATA, CSUM} loader_state_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} uart_rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling, one-cycle
// byte_valid or frame_err pulse after the stop-bit sample.
module uart_rx
    import soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rxd,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    uart_rx_state_t state, state_next;
    logic           rxd_meta, rxd_sync, rxd_prev;
    logic [CW-1:0]  cnt, cnt_next;
    logic [2:0]     bit_idx, bit_idx_next;
    logic [7:0]     shift, shift_next;
    logic           valid_next, ferr_next;

    assign byte_data = shift;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rxd_meta   <= 1'b1;
            rxd_sync   <= 1'b1;
            rxd_prev   <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxd_meta   <= rxd;
            rxd_sync   <= rxd_meta;
            rxd_prev   <= rxd_sync;
            state      <= state_next;
            cnt        <= cnt_next;
            bit_idx    <= bit_idx_next;
            shift      <= shift_next;
            byte_valid <= valid_next;
            frame_err  <= ferr_next;
        end
    end

    // A start bit that has gone high again by its mid-point is treated as a glitch.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt + 1'b1;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        valid_next   = 1'b0;
        ferr_next    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                cnt_next = '0;
                if (rxd_prev && !rxd_sync) state_next = RX_START;
            end
            RX_START: begin
                if (cnt == HALF) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    state_next   = rxd_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt == FULL) begin
                    cnt_next     = '0;
                    shift_next   = {rxd_sync, shift[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt == FULL) begin
                    cnt_next   = '0;
                    state_next = RX_IDLE;
                    valid_next = rxd_sync;
                    ferr_next  = !rxd_sync;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a framed program image from the UART into BRAM, holding the core in
// reset for the duration of each frame.
module uart_prog_loader
    import soc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT_CYC  = 65536
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rxd,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int MEM_WORDS = 2 ** ADDR_W;
    localparam int TW        = $clog2(TIMEOUT_CYC + 1);

    logic       byte_valid, frame_err;
    logic [7:0] byte_data;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .resetn    (resetn),
        .rxd       (rxd),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] len, len_next, waddr, waddr_next, addr_next;
    logic [1:0]        idx, idx_next;
    logic [23:0]       lanes, lanes_next;
    logic [7:0]        csum, csum_next;
    logic [TW-1:0]     tcnt, tcnt_next;
    logic [31:0]       wdata_next;
    logic              we_next, hold_next, done_next, err_next, abort;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            len       <= '0;
            waddr     <= '0;
            idx       <= '0;
            lanes     <= '0;
            csum      <= '0;
            tcnt      <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_next;
            len       <= len_next;
            waddr     <= waddr_next;
            idx       <= idx_next;
            lanes     <= lanes_next;
            csum      <= csum_next;
            tcnt      <= tcnt_next;
            mem_we    <= we_next;
            mem_addr  <= addr_next;
            mem_wdata <= wdata_next;
            core_hold <= hold_next;
            load_done <= done_next;
            load_err  <= err_next;
        end
    end

    // tcnt holds the number of cycles since the last byte, so load_err lands
    // exactly TIMEOUT_CYC cycles after it; a simultaneous frame_err is the same abort.
    always_comb begin
        state_next = state;
        len_next   = len;
        waddr_next = waddr;
        idx_next   = idx;
        lanes_next = lanes;
        csum_next  = csum;
        we_next    = 1'b0;
        addr_next  = mem_addr;
        wdata_next = mem_wdata;
        hold_next  = core_hold;
        done_next  = load_done;
        err_next   = load_err;
        tcnt_next  = (byte_valid || state == IDLE) ? TW'(1) : tcnt + 1'b1;
        abort      = (state != IDLE) &&
                     (frame_err || (!byte_valid && tcnt == TW'(TIMEOUT_CYC - 1)));

        if (abort) begin
            state_next = IDLE;
            hold_next  = 1'b0;
            err_next   = 1'b1;
        end else if (byte_valid) begin
            unique case (state)
                IDLE: begin
                    if (byte_data == LOADER_SYNC) begin
                        state_next = LEN;
                        hold_next  = 1'b1;
                        done_next  = 1'b0;
                        err_next   = 1'b0;
                        csum_next  = '0;
                        waddr_next = '0;
                        idx_next   = '0;
                    end
                end
                LEN: begin
                    if (int'(byte_data) >= MEM_WORDS) begin
                        state_next = IDLE;
                        hold_next  = 1'b0;
                        err_next   = 1'b1;
                    end else begin
                        len_next   = ADDR_W'(byte_data);
                        state_next = DATA;
                    end
                end
                DATA: begin
                    csum_next = csum ^ byte_data;
                    idx_next  = idx + 1'b1;
                    if (idx == 2'd3) begin
                        we_next    = 1'b1;
                        addr_next  = waddr;
                        wdata_next = {byte_data, lanes};
                        waddr_next = waddr + 1'b1;
                        if (waddr == len) state_next = CSUM;
                    end else begin
                        lanes_next = {byte_data, lanes[23:8]};
                    end
                end
                CSUM: begin
                    if (byte_data == csum) done_next = 1'b1;
                    else                   err_next  = 1'b1;
                    hold_next  = 1'b0;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: expected BRAM writes are queued as frames are sent and
// compared against each mem_we pulse; flags are checked after each frame.
module tb_uart_prog_loader;

    localparam int CPB = 8;
    localparam int AW  = 4;
    localparam int TOC = 400;

    logic          clk = 1'b0;
    logic          resetn;
    logic          rxd;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold, load_done, load_err;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         bv_cycle = -1;
    logic       prev_hold = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    logic [7:0] cs;
    logic [31:0] w;
    wr_t        got;

    uart_prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .TIMEOUT_CYC (TOC)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rxd      (rxd),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .core_hold(core_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err,
                               input logic hold);
        checkOutput({tag, "_done"}, 64'(load_done), 64'(done));
        checkOutput({tag, "_err"},  64'(load_err),  64'(err));
        checkOutput({tag, "_hold"}, 64'(core_hold), 64'(hold));
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic send_queue();
        foreach (tx_q[i]) applyStimulus(tx_q[i], 1'b1);
        tx_q.delete();
    endtask

    task automatic push_wr(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = AW'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic load_spec_frame(input logic [7:0] c);
        push_wr(0, 32'h0000_0033);
        push_wr(1, 32'h0010_0093);
        tx_q = '{8'hA5, 8'h01, 8'h33, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, c};
        send_queue();
        repeat (3 * CPB) @(negedge clk);
    endtask

    // Monitor: scoreboard pops on every write pulse; core_hold must drop as a flag rises.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (dut.u_rx.byte_valid) bv_cycle = cyc;
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                checkOutput("we_unexpected", 64'(mem_we), 64'd0);
            end else begin
                got = exp_q.pop_front();
                checkOutput("wr_addr", 64'(mem_addr), 64'(got.addr));
                checkOutput("wr_data", 64'(mem_wdata), 64'(got.data));
            end
        end
        if (resetn && ((load_done && !prev_done) || (load_err && !prev_err)))
            checkOutput("hold_drop_with_flag", 64'({prev_hold, core_hold}), 64'b10);
        prev_hold = core_hold;
        prev_done = load_done;
        prev_err  = load_err;
    end

    initial begin
        #800_000;
        $display("[TB] FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn = 1'b0;
        rxd    = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_outputs",
                    64'({mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err}), 64'd0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_queue();
        repeat (3 * CPB) @(negedge clk);
        check_flags("noise", 1'b0, 1'b0, 1'b0);

        applyStimulus(8'hA5, 1'b1);
        repeat (2 * CPB) @(negedge clk);
        check_flags("after_sync", 1'b0, 1'b0, 1'b1);
        push_wr(0, 32'h0000_0033);
        push_wr(1, 32'h0010_0093);
        tx_q = '{8'h01, 8'h33, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_queue();
        checkOutput("hold_before_csum", 64'(core_hold), 64'd1);
        applyStimulus(8'hB0, 1'b1);
        repeat (3 * CPB) @(negedge clk);
        check_flags("good", 1'b1, 1'b0, 1'b0);
        checkOutput("good_sb_empty", 64'(exp_q.size()), 64'd0);

        load_spec_frame(8'h00);
        check_flags("bad_csum", 1'b0, 1'b1, 1'b0);
        checkOutput("bad_csum_sb_empty", 64'(exp_q.size()), 64'd0);

        tx_q = '{8'hA5, 8'h01, 8'h33, 8'h00};
        send_queue();
        applyStimulus(8'h00, 1'b0);
        repeat (3 * CPB) @(negedge clk);
        check_flags("ferr", 1'b0, 1'b1, 1'b0);
        load_spec_frame(8'hB0);
        check_flags("after_ferr", 1'b1, 1'b0, 1'b0);
        checkOutput("after_ferr_sb_empty", 64'(exp_q.size()), 64'd0);

        tx_q = '{8'hA5, 8'h10};
        send_queue();
        repeat (3 * CPB) @(negedge clk);
        check_flags("oversize", 1'b0, 1'b1, 1'b0);

        cs = 8'h00;
        tx_q.push_back(8'hA5);
        tx_q.push_back(8'h0F);
        for (int i = 0; i < 16; i++) begin
            w = $urandom;
            push_wr(i, w);
            for (int b = 0; b < 4; b++) begin
                tx_q.push_back(w[8*b +: 8]);
                cs = cs ^ w[8*b +: 8];
            end
        end
        tx_q.push_back(cs);
        send_queue();
        repeat (3 * CPB) @(negedge clk);
        check_flags("full_mem", 1'b1, 1'b0, 1'b0);
        checkOutput("full_mem_sb_empty", 64'(exp_q.size()), 64'd0);

        tx_q = '{8'hA5, 8'h00, 8'h11, 8'h22, 8'h33};
        send_queue();
        begin
            int t;
            t = 0;
            while (!load_err && t < TOC + 20 * CPB) begin
                @(negedge clk);
                t++;
            end
        end
        checkOutput("timeout_seen", 64'(load_err), 64'd1);
        checkOutput("timeout_latency", 64'(cyc - bv_cycle), 64'(TOC));
        check_flags("timeout", 1'b0, 1'b1, 1'b0);

        push_wr(0, 32'h4433_2211);
        tx_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        send_queue();
        checkOutput("hold_before_reset", 64'(core_hold), 64'd1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midframe_reset_outputs",
                    64'({mem_we, mem_addr, mem_wdata, core_hold, load_done, load_err}), 64'd0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        load_spec_frame(8'hB0);
        check_flags("after_reset", 1'b1, 1'b0, 1'b0);
        checkOutput("after_reset_sb_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
